// File: rtl/eq_band_mixer.sv
// Five-band equalizer mixer: per-band Q2.14 gains (double-buffered) applied to Q1.15
// band samples through one time-multiplexed MAC, then rounded and saturated to Q1.15.
module eq_band_mixer #(
    parameter int NBANDS = 5,
    parameter int DW     = 16,
    parameter int GW     = 16,
    parameter int ACCW   = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NBANDS*DW-1:0] bands_in,
    input  logic                 gain_we,
    input  logic [2:0]           gain_addr,
    input  logic [GW-1:0]        gain_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        data_out,
    output logic                 sat_flag
);

    localparam int SW   = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam int FRAC = GW - 2;
    localparam logic [3:0] NB4 = 4'(NBANDS);
    localparam logic signed [ACCW-1:0] RND = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic [GW-1:0] UNITY = {2'b01, {(GW-2){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DW-1:0]          r_data_out;
    logic                   r_sat_flag;
    logic [GW-1:0]          r_stage  [NBANDS];
    logic [GW-1:0]          r_active [NBANDS];
    logic [DW-1:0]          r_band   [NBANDS];
    logic signed [ACCW-1:0] r_acc;
    logic [3:0]             r_idx;

    logic [SW-1:0]          w_sel;
    logic signed [DW-1:0]   w_band_sel;
    logic signed [GW-1:0]   w_gain_sel;
    logic signed [DW+GW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_rnd_sum;
    logic signed [ACCW-1:0] w_shift;
    logic [ACCW-DW:0]       w_hi;
    logic [DW-1:0]          w_res;
    logic                   w_sat;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign sat_flag  = r_sat_flag;

    assign w_sel      = (r_idx < NB4) ? r_idx[SW-1:0] : {SW{1'b0}};
    assign w_band_sel = r_band[w_sel];
    assign w_gain_sel = r_active[w_sel];
    assign w_prod     = w_band_sel * w_gain_sel;
    assign w_prod_ext = {{(ACCW-DW-GW){w_prod[DW+GW-1]}}, w_prod};
    assign w_rnd_sum  = r_acc + RND;
    assign w_shift    = w_rnd_sum >>> FRAC;
    assign w_hi       = w_shift[ACCW-1:DW-1];

    // Round-half-up result clipped to the Q1.15 range.
    always_comb begin
        w_res = w_shift[DW-1:0];
        w_sat = 1'b0;
        if ((&w_hi) || (~|w_hi)) begin
            w_res = w_shift[DW-1:0];
            w_sat = 1'b0;
        end else if (w_shift[ACCW-1]) begin
            w_res = {1'b1, {(DW-1){1'b0}}};
            w_sat = 1'b1;
        end else begin
            w_res = {1'b0, {(DW-1){1'b1}}};
            w_sat = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_next = MAC;
                else          w_state_next = IDLE;
            end
            // One extra MAC cycle at idx==NBANDS turns the finished sum into the output.
            MAC: begin
                if (r_idx == NB4) w_state_next = OUT;
                else              w_state_next = MAC;
            end
            OUT: begin
                if (out_ready) w_state_next = IDLE;
                else           w_state_next = OUT;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == OUT);
        end
    end

    // Gain staging, sample capture, accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANDS; b++) begin
                r_stage[b]  <= UNITY;
                r_active[b] <= UNITY;
                r_band[b]   <= {DW{1'b0}};
            end
            r_acc      <= {ACCW{1'b0}};
            r_idx      <= 4'd0;
            r_data_out <= {DW{1'b0}};
            r_sat_flag <= 1'b0;
        end else begin
            if (gain_we && ({1'b0, gain_addr} < NB4)) begin
                r_stage[gain_addr[SW-1:0]] <= gain_wdata;
            end
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int b = 0; b < NBANDS; b++) begin
                            r_band[b]   <= bands_in[b*DW +: DW];
                            r_active[b] <= r_stage[b];
                        end
                        r_acc <= {ACCW{1'b0}};
                        r_idx <= 4'd0;
                    end
                end
                MAC: begin
                    if (r_idx == NB4) begin
                        r_data_out <= w_res;
                        r_sat_flag <= w_sat;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                        r_idx <= r_idx + 4'd1;
                    end
                end
                OUT: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: directed test-plan steps plus randomized
// samples, checked against an integer-arithmetic reference of the mixing rule.
module tb_eq_band_mixer;

    localparam int NB = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [NB*16-1:0] bands_in;
    logic           gain_we;
    logic [2:0]     gain_addr;
    logic [15:0]    gain_wdata;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    data_out;
    logic           sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_stage  [8];
    logic [15:0] m_active [8];

    eq_band_mixer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bands_in(bands_in), .gain_we(gain_we), .gain_addr(gain_addr),
        .gain_wdata(gain_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Reference staging gains: writes to bands >= NB are dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_stage[i] <= 16'h4000;
        end else if (gain_we && (int'(gain_addr) < NB)) begin
            m_stage[gain_addr] <= gain_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void calc(input logic [NB*16-1:0] b, output logic [15:0] d, output logic s);
        longint sum;
        longint r;
        sum = 0;
        for (int i = 0; i < NB; i++)
            sum += longint'($signed(b[i*16 +: 16])) * longint'($signed(m_active[i]));
        r = (sum + 64'sd8192) >>> 14;
        if (r > 32767)       begin d = 16'h7FFF; s = 1'b1; end
        else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
        else                 begin d = r[15:0];  s = 1'b0; end
    endfunction

    task automatic write_gain(input logic [2:0] a, input logic [15:0] d);
        gain_we = 1'b1; gain_addr = a; gain_wdata = d;
        @(negedge clk);
        gain_we = 1'b0;
    endtask

    // One full transaction; optional gain write on the accept edge or during MAC,
    // optional backpressure of 'hold' cycles, optional constant expectation.
    task automatic run_sample(input string tag, input logic [NB*16-1:0] b, input int hold,
                              input bit wr_acc, input bit wr_mac, input logic [2:0] wa,
                              input logic [15:0] wd, input bit has_c, input logic [15:0] cd,
                              input bit cs);
        int n;
        logic [15:0] ed;
        logic es;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; bands_in = b;
        if (wr_acc) begin gain_we = 1'b1; gain_addr = wa; gain_wdata = wd; end
        @(posedge clk);
        m_active = m_stage;
        calc(b, ed, es);
        @(negedge clk);
        in_valid = 1'b0; gain_we = 1'b0;
        chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (wr_mac && n == 1) begin gain_we = 1'b1; gain_addr = wa; gain_wdata = wd; end
            else gain_we = 1'b0;
            @(negedge clk); n++;
        end
        gain_we = 1'b0;
        chk({tag, "_latency"}, n, 32'd6);
        chk({tag, "_data"}, {15'd0, sat_flag, data_out}, {15'd0, es, ed});
        if (has_c) chk({tag, "_const"}, {15'd0, sat_flag, data_out}, {15'd0, cs, cd});
        if (hold > 0) begin
            in_valid = 1'b1; bands_in = {$urandom, $urandom, $urandom};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold"}, {13'd0, out_valid, in_ready, sat_flag, data_out},
                    {13'd0, 1'b1, 1'b0, es, ed});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_handshake"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [NB*16-1:0] bv;
        rst_n = 1'b0; in_valid = 1'b0; bands_in = '0; gain_we = 1'b0;
        gain_addr = 3'd0; gain_wdata = 16'h0000; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) m_active[i] = 16'h4000;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {13'd0, in_ready, out_valid, sat_flag, data_out}, {13'd0, 3'b100, 16'h0000});
        rst_n = 1'b1;
        @(negedge clk);

        run_sample("unity", {NB{16'h1000}}, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h5000, 1'b0);
        run_sample("sat_pos", {NB{16'h7FFF}}, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h7FFF, 1'b1);
        run_sample("sat_neg", {NB{16'h8000}}, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h8000, 1'b1);

        write_gain(3'd2, 16'h8000);
        bv = '0; bv[32 +: 16] = 16'h1000;
        run_sample("neg_gain", bv, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'hE000, 1'b0);
        write_gain(3'd0, 16'h2000);
        bv = '0; bv[0 +: 16] = 16'h0003;
        run_sample("round", bv, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h0002, 1'b0);
        write_gain(3'd6, 16'h0000);
        run_sample("addr6", {NB{16'h1000}}, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h1800, 1'b0);
        write_gain(3'd0, 16'h4000);
        write_gain(3'd2, 16'h4000);

        run_sample("dbuf_a", {NB{16'h1000}}, 0, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1, 16'h5000, 1'b0);
        run_sample("dbuf_b", {NB{16'h1000}}, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h4000, 1'b0);
        run_sample("acc_wr", {NB{16'h1000}}, 0, 1'b1, 1'b0, 3'd1, 16'h4000, 1'b1, 16'h4000, 1'b0);
        run_sample("acc_nx", {NB{16'h1000}}, 10, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h5000, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_second_accept", {31'd0, out_valid}, 32'd0);

        for (int k = 0; k < 10; k++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                write_gain(3'($urandom_range(0, 7)), 16'($urandom));
            bv = {$urandom, $urandom, $urandom};
            run_sample("rand", bv, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       1'b0, 16'h0, 1'b0);
        end

        write_gain(3'd0, 16'h0000);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1; bands_in = {NB{16'h1000}};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) m_active[i] = 16'h4000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_no_out", {31'd0, out_valid}, 32'd0);
        end
        bv = '0; bv[0 +: 16] = 16'h1000;
        run_sample("post_rst", bv, 0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
